tone_synth: RTL

TONE_SYNTH -- requirements
Module: tone_synth

---
 rtl/tone_pkg.sv | 28 ++
 rtl/tone_synth_if.sv | 15 +
 rtl/tone_channel.sv | 58 +++++
 rtl/tone_synth.sv | 95 +++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone synthesizer: note codes and
// their square-wave half-periods in 50 MHz clock cycles.
package tone_pkg;

  typedef enum logic [2:0] {
    NOTE_DO  = 3'd0,
    NOTE_RE  = 3'd1,
    NOTE_MI  = 3'd2,
    NOTE_FA  = 3'd3,
    NOTE_SO  = 3'd4,
    NOTE_LA  = 3'd5,
    NOTE_SI  = 3'd6,
    NOTE_DO2 = 3'd7
  } note_t;

  localparam int DEF_SAMPLE_W = 24;

  // Packed so that element [0] (rightmost) is Do and element [7] is Do2.
  localparam logic [7:0][15:0] HALF_PERIOD = {
    16'd23889, 16'd25310, 16'd28409, 16'd31888,
    16'd35793, 16'd37922, 16'd42566, 16'd47778
  };

  function automatic logic [15:0] half_period(input note_t n);
    return HALF_PERIOD[n];
  endfunction

endpackage

// File: rtl/tone_synth_if.sv
// Sample-set handshake between the tone synthesizer (master) and the audio
// sink (slave): one valid/ready pair qualifying all channel samples at once.
interface tone_synth_if import tone_pkg::*; #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = DEF_SAMPLE_W
);

  logic                         audio_valid;
  logic                         audio_ready;
  logic [NUM_CH*SAMPLE_W-1:0]   ch_data;

  modport master (output audio_valid, output ch_data, input  audio_ready);
  modport slave  (input  audio_valid, input  ch_data, output audio_ready);

endinterface

// File: rtl/tone_channel.sv
// One square-wave tone channel: registered note code, half-period divider
// and phase, producing a signed +/-AMP sample (zero when disabled).
module tone_channel import tone_pkg::*; #(
  parameter int                  SAMPLE_W = DEF_SAMPLE_W,
  parameter logic [SAMPLE_W-1:0] AMP      = SAMPLE_W'(24'h100000)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  note_t                      note_i,
  output note_t                      note_o,
  output logic signed [SAMPLE_W-1:0] sample_o
);

  localparam logic signed [SAMPLE_W-1:0] AMP_S = AMP;

  note_t       note_q;
  logic        chg_q;
  logic [15:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  function automatic logic signed [SAMPLE_W-1:0] square_sample(input logic gate,
                                                               input logic ph);
    if (!gate) return '0;
    return ph ? AMP_S : -AMP_S;
  endfunction

  // A note change seen last cycle restarts the waveform from phase 0.
  always_comb begin
    cnt_d   = cnt_q + 16'd1;
    phase_d = phase_q;
    if (chg_q) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == half_period(note_q) - 16'd1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_q  <= NOTE_DO;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      note_q  <= note_i;
      chg_q   <= (note_i != note_q);
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign note_o   = note_q;
  assign sample_o = square_sample(en_i, phase_q);

endmodule

// File: rtl/tone_synth.sv
// Multi-channel square-wave tone synthesizer with a sample-rate strobe and a
// valid/ready sample-set output. Define TONE_OVERRUN_FLAG_EN for a sticky overrun flag.
module tone_synth import tone_pkg::*; #(
  parameter int                  NUM_CH     = 2,
  parameter int                  SAMPLE_W   = DEF_SAMPLE_W,
  parameter logic [SAMPLE_W-1:0] AMP        = SAMPLE_W'(24'h100000),
  parameter int                  SAMPLE_DIV = 1042
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                en,
  input  logic [NUM_CH*3-1:0] note_sel,
  output logic [2:0]          note_disp,
`ifdef TONE_OVERRUN_FLAG_EN
  output logic                overrun,
`endif
  tone_synth_if.master        aud
);

  localparam int               DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0]           div_q, div_d;
  logic                       strobe_q, strobe_d;
  logic                       vld_q, vld_d;
  logic [NUM_CH*SAMPLE_W-1:0] data_q, data_d;
  logic [NUM_CH*SAMPLE_W-1:0] samples;
  logic [2:0]                 disp_q;
  note_t                      note_all [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    tone_channel #(
      .SAMPLE_W (SAMPLE_W),
      .AMP      (AMP)
    ) u_ch (
      .clk      (CLOCK_50),
      .rst      (reset),
      .en_i     (en),
      .note_i   (note_t'(note_sel[3*k +: 3])),
      .note_o   (note_all[k]),
      .sample_o (samples[k*SAMPLE_W +: SAMPLE_W])
    );
  end

  // The strobe is registered, so a capture lands one cycle after the divider wraps.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    strobe_d = (div_q == DIV_LAST);
    vld_d    = vld_q;
    data_d   = data_q;
    if (strobe_q) begin
      vld_d  = 1'b1;
      data_d = samples;
    end else if (vld_q && aud.audio_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      strobe_q <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      disp_q   <= '0;
    end else begin
      div_q    <= div_d;
      strobe_q <= strobe_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      disp_q   <= note_all[0];
    end
  end

`ifdef TONE_OVERRUN_FLAG_EN
  logic ovr_q, ovr_d;

  // Overwriting a set the sink never took; a coinciding transfer is not an overrun.
  always_comb begin
    ovr_d = ovr_q | (strobe_q & vld_q & ~aud.audio_ready);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign overrun = ovr_q;
`endif

  assign aud.audio_valid = vld_q;
  assign aud.ch_data     = data_q;
  assign note_disp       = disp_q;

endmodule
